// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit controller owning the HI/LO registers.
// Define MDU_DIV_EN to build the divider; otherwise div/divu issue as no-ops.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        op_valid, launch, done, commit;
  logic        op_div, div_zero;
  logic [31:0] pend_hi, pend_lo;
  logic [31:0] res_hi, res_lo;
  logic        res_zero;
  logic [63:0] prod_s, prod_u;

`ifdef MDU_DIV_EN
  logic        div_signed;
  logic [31:0] dvd_mag, dvs_mag, dvs_safe, quo_mag, rem_mag, quo, rem;

  assign op_valid = ~md_sel[2];

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. A zero divisor is replaced so no X appears.
  always_comb begin
    div_signed = ~md_sel[0];
    dvd_mag    = (div_signed & A[31]) ? (32'd0 - A) : A;
    dvs_mag    = (div_signed & B[31]) ? (32'd0 - B) : B;
    dvs_safe   = (B == 32'd0) ? 32'd1 : dvs_mag;
    quo_mag    = dvd_mag / dvs_safe;
    rem_mag    = dvd_mag % dvs_safe;
    quo        = (div_signed & (A[31] ^ B[31])) ? (32'd0 - quo_mag) : quo_mag;
    rem        = (div_signed & A[31]) ? (32'd0 - rem_mag) : rem_mag;
  end
`else
  assign op_valid = (md_sel[2:1] == 2'b00);
`endif

  assign launch = (state == IDLE) & start & op_valid;
  assign busy   = (state == RUN);
  assign done   = busy & (cnt == 4'd1);
  assign commit = ~(op_div & div_zero);
  assign stall  = reset & md_use_D & (start | busy);

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  always_comb begin
    res_hi   = prod_u[63:32];
    res_lo   = prod_u[31:0];
    res_zero = 1'b0;
    if (md_sel[1:0] == 2'b00) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end
`ifdef MDU_DIV_EN
    if (md_sel[1]) begin
      res_hi   = rem;
      res_lo   = quo;
      res_zero = (B == 32'd0);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (launch) begin
          state_next = RUN;
          cnt_next   = md_sel[1] ? 4'd10 : 4'd5;
        end
      end
      RUN: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Result is computed at issue and held until the countdown expires; a
  // divide by zero completes without touching HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_div   <= 1'b0;
      div_zero <= 1'b0;
      pend_hi  <= 32'd0;
      pend_lo  <= 32'd0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else begin
      if (launch) begin
        op_div   <= md_sel[1];
        div_zero <= res_zero;
        pend_hi  <= res_hi;
        pend_lo  <= res_lo;
      end
      if (done && commit) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end else if ((state == IDLE) && !launch) begin
        if (hi_we) HI <= A;
        if (lo_we) LO <= A;
      end
    end
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL declare ports: clk  in  1  single clock, rising edge.
REQ-002 SHALL declare: reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-003 SHALL declare: start  in  1  E-stage mult/multu/div/divu issue pulse.
REQ-004 SHALL declare: md_sel  in  3  operation (0 mult, 1 multu, 2 div, 3 divu; 4-7 treated as no-op).
REQ-005 SHALL declare: A, B  in  32 each  forwarded rs/rt operands in E.
REQ-006 SHALL declare: hi_we, lo_we  in  1 each  mthi/mtlo write enables in E.
REQ-007 SHALL declare: md_use_D  in  1  D-stage instruction is any mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL declare: busy  out  1  unit occupied; stall  out  1  freeze F/D, bubble E.
REQ-009 SHALL declare: HI, LO  out  32 each  architectural HI/LO registers.

Function
REQ-010 SHALL implement FSM states IDLE and RUN plus a 4-bit down-counter cnt.
REQ-011 In IDLE with start=1 and valid md_sel, SHALL latch md_sel, compute result from A/B of that cycle into pending regs, load cnt (mult/multu 5, div/divu 10), go to RUN.
REQ-012 In RUN, cnt SHALL decrement each cycle; at cnt==1 SHALL write pending result to HI/LO and return to IDLE on the next edge.
REQ-013 busy SHALL equal (state==RUN); first busy cycle is the cycle after start; mult busy 5 cycles, div busy 10 cycles.
REQ-014 stall SHALL equal md_use_D & (start | busy), combinational.
REQ-015 mult: {HI,LO} = signed(A)*signed(B), 64-bit; multu: unsigned product.
REQ-016 div: LO = quotient truncated toward zero, HI = remainder with dividend's sign; divu unsigned.
REQ-017 0x80000000 div 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-018 Divisor zero: SHALL run full 10-cycle busy, HI/LO unchanged at completion.
REQ-019 start while busy SHALL be ignored (no restart, no operand capture).
REQ-020 hi_we/lo_we in IDLE SHALL write A to HI/LO on that edge; ignored while busy.
REQ-021 start and hi_we/lo_we in same IDLE cycle: start SHALL win, write ignored.
REQ-022 HI/LO SHALL change only at REQ-012 completion or REQ-020 write.
REQ-023 md_sel 4-7 with start=1 SHALL be a no-op: stay IDLE, busy=0.

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, cnt=0, busy=0, HI=0, LO=0, pending regs=0, independent of clk.
REQ-025 reset asserted mid-RUN SHALL abort the operation; no HI/LO write after release.
REQ-026 stall SHALL be 0 during reset regardless of md_use_D and start.

Configuration
REQ-027 Macro MDU_DIV_EN defined: div/divu SHALL behave per REQ-011..018.
REQ-028 MDU_DIV_EN undefined: md_sel 2/3 SHALL be no-ops as REQ-023; no divider logic synthesized; mult/multu unchanged.

Verification
REQ-029 mult A=0xFFFFFFFE, B=0x00000003 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 multu A=0xFFFFFFFF, B=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-031 div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; without MDU_DIV_EN busy stays 0, HI/LO unchanged.
REQ-032 div A=5, B=0 with HI=0x11, LO=0x22 -> 10 busy cycles, HI=0x11, LO=0x22 after.
REQ-033 start mult, md_use_D=1 during busy -> stall=1 from start cycle through last busy cycle; mthi A=7 while busy ignored; mthi A=7 in IDLE -> HI=7 next edge.
REQ-034 reset=0 on 3rd busy cycle of multu -> busy=0, HI=LO=0 immediately, remain 0 for 10 cycles after release.
